// File: rtl/reg_bus_decoder.sv
// Initiator side of the PWM register bus: turns SPI instruction/data byte pairs
// into register read/write strobes and returns read data as the next SPI byte.
module reg_bus_decoder #(
  parameter int unsigned           ADDR_W   = 6,
  parameter int unsigned           DATA_W   = 8,
  parameter logic [ADDR_W-1:0]     MAX_ADDR = 6'h0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RD, DATA} state_t;

  state_t              state, state_nx;
  logic                rw_q, rw_nx;
  logic                read_nx, write_nx, err_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   dw_nx, dout_nx;

  // Instruction byte fields; bit DATA_W-2 is reserved.
  logic                in_rw, in_ok, addr_ok;
  logic [ADDR_W-1:0]   in_addr;

  assign in_rw   = data_in[DATA_W-1];
  assign in_addr = data_in[ADDR_W-1:0];
  assign in_ok   = (in_addr <= MAX_ADDR);
  assign addr_ok = (addr <= MAX_ADDR);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rw_q       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      err        <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      data_out   <= '0;
    end else begin
      state      <= state_nx;
      rw_q       <= rw_nx;
      read       <= read_nx;
      write      <= write_nx;
      err        <= err_nx;
      addr       <= addr_nx;
      data_write <= dw_nx;
      data_out   <= dout_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!frame_active) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (byte_sync) state_nx = (!in_rw && in_ok) ? RD : DATA;
        RD:      state_nx = DATA;
        DATA:    if (byte_sync) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; a dropped frame leaves them quiet.
  always_comb begin
    rw_nx    = rw_q;
    read_nx  = 1'b0;
    write_nx = 1'b0;
    err_nx   = 1'b0;
    addr_nx  = addr;
    dw_nx    = data_write;
    dout_nx  = data_out;
    if (frame_active) begin
      case (state)
        IDLE: if (byte_sync) begin
          rw_nx   = in_rw;
          addr_nx = in_addr;
          if (!in_rw) begin
            if (in_ok) begin
              read_nx = 1'b1;
            end else begin
              dout_nx = '0;
              err_nx  = 1'b1;
            end
          end
        end
        RD: begin
          dout_nx = data_read;
          err_nx  = byte_sync;   // byte arriving mid-read is dropped
        end
        DATA: if (byte_sync && rw_q) begin
          if (addr_ok) begin
            dw_nx    = data_in;
            write_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_bus_decoder.md
Name: reg_bus_decoder

Overview:
- Initiator side of the PWM register bus.
- Converts the byte stream from the SPI bridge into read/write strobes, an address and write data for the register file.
- Captures the register file's read data into the byte returned to the SPI bridge.
- A transaction is two bytes: an instruction byte, then a data byte (write) or a dummy byte (read).

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 8, bus data width and SPI byte width.
- MAX_ADDR, 6'h0F, highest implemented register address; addresses above it are rejected.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- frame_active  input  1  SPI chip-select active; low aborts any transaction
- byte_sync  input  1  one-cycle pulse; data_in valid in that cycle
- data_in  input  DATA_W  byte received from SPI bridge
- data_out  output  DATA_W  byte for SPI bridge to shift out next
- read  output  1  register read strobe
- write  output  1  register write strobe
- addr  output  ADDR_W  register address
- data_read  input  DATA_W  register file read data, combinational from addr while read high
- data_write  output  DATA_W  register write data
- busy  output  1  transaction in progress (state != IDLE)
- err  output  1  one-cycle pulse on protocol/address error

Behaviour:
- Reset (rst high at posedge): state=IDLE; read, write, err = 0; addr, data_write, data_out = 0.
- All outputs are registered. rst has priority over every other input.
- Instruction byte format:
  - bit7: 1 = write, 0 = read.
  - bit6: reserved, ignored.
  - bits5:0: address.
- Invalid address: address > MAX_ADDR.

FSM, states IDLE, RD, DATA:
- IDLE, byte_sync=1 and frame_active=1:
  - Latch rw and addr.
  - Read, valid address: go to RD.
  - Read, invalid address: data_out<=0x00, err pulse, go to DATA.
  - Write: go to DATA. Address validity is checked later, at the data byte.
- RD (exactly one cycle):
  - read=1 for this cycle, with addr stable.
  - At the ending edge: data_out<=data_read, read<=0, go to DATA.
- DATA, write transaction, byte_sync=1:
  - Valid address: data_write<=data_in; write=1 for exactly the next cycle, addr unchanged; go to IDLE.
  - Invalid address: no write strobe, err pulse, go to IDLE.
- DATA, read transaction, byte_sync=1: dummy byte, data ignored, go to IDLE. data_out holds its value until the next read.

Latency:
- write strobe: 1 cycle after the data-byte byte_sync.
- read strobe: 1 cycle after the instruction byte_sync.
- data_out valid: 2 cycles after the instruction byte_sync, well before the next SPI byte completes.

Boundary conditions:
- frame_active=0 in any state: next state is IDLE; read and write are forced 0; byte_sync in that cycle is ignored; no err. A pending write is dropped.
- byte_sync during RD: protocol violation. Byte dropped, err pulse, RD completes normally.
- read and write are never high in the same cycle. Each is a single-cycle pulse per transaction.
- addr is held after a transaction until the next instruction byte.
- Back-to-back transactions: a byte_sync in the same cycle the FSM returns to IDLE (write pulse cycle) is accepted as the next instruction.

Test Plan:
- Write 0x00←0xBA, then 0x01←0xAB → bytes 0x80,0xBA,0x81,0xAB. Required: write pulses one cycle each with addr=0x00/data_write=0xBA, then addr=0x01/data_write=0xAB; with regs attached, period=0xABBA.
- Read 0x0A after prescale=0x42 → bytes 0x0A, dummy 0x00. Required: read high exactly one cycle, 1 cycle after the first byte_sync; data_out=0x42 two cycles after it; no write.
- Read 0x08 with counter_val=0x1234 → data_out=0x34; then read 0x09 → data_out=0x12.
- Out-of-range: instruction 0x95 (write 0x15), data 0x77 → no write strobe, err pulse; instruction 0x1F (read 0x1F) → no read strobe, data_out=0x00, err pulse.
- Abort: send 0x87, drop frame_active for one cycle, then byte_sync 0xFF → no write, no err, busy=0; the next 0x07,0xFF pair with frame_active high is treated as a read of 0x07.
- Reset mid-transaction: rst high in DATA after instruction 0x80 → all outputs 0 and state IDLE next cycle; a subsequent byte_sync 0x55 is decoded as an instruction (read 0x15, rejected, err).
